// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - writeback arbiter merging per-pipe result FIFOs onto one register-file write port
//
// Purpose: each execution pipe pushes results into its own small FIFO; every
// cycle one FIFO head is granted (fixed priority or round-robin) and retired
// through a registered register-file write port.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             discard all queued entries (beats push and grant)
//   pipe_valid/ready  per-pipe push handshake
//   pipe_reg_write    per-pipe: entry writes the register file
//   pipe_rd           per-pipe destination register, packed REG_WIDTH each
//   pipe_data         per-pipe result data, packed 32 bits each
//   wb_wr_en/rd/data  registered register-file write port
//   retire_valid      one entry retired this cycle (registered)
//   retire_pipe       one-hot source of the retired entry (registered)
//   occupancy         per-FIFO entry count, packed
module wb_arbiter #(
  parameter int NUM_PIPES  = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ARB_MODE   = 0,
  parameter int REG_WIDTH  = 5
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         flush,
  input  logic [NUM_PIPES-1:0]                         pipe_valid,
  output logic [NUM_PIPES-1:0]                         pipe_ready,
  input  logic [NUM_PIPES-1:0]                         pipe_reg_write,
  input  logic [NUM_PIPES*REG_WIDTH-1:0]               pipe_rd,
  input  logic [NUM_PIPES*32-1:0]                      pipe_data,
  output logic                                         wb_wr_en,
  output logic [REG_WIDTH-1:0]                         wb_rd,
  output logic [31:0]                                  wb_wr_data,
  output logic                                         retire_valid,
  output logic [NUM_PIPES-1:0]                         retire_pipe,
  output logic [NUM_PIPES*$clog2(FIFO_DEPTH+1)-1:0]    occupancy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = (NUM_PIPES > 1) ? $clog2(NUM_PIPES) : 1;

  logic [REG_WIDTH-1:0] mem_rd   [NUM_PIPES][FIFO_DEPTH];
  logic [31:0]          mem_data [NUM_PIPES][FIFO_DEPTH];
  logic                 mem_wr   [NUM_PIPES][FIFO_DEPTH];

  logic [PW-1:0] wptr  [NUM_PIPES];
  logic [PW-1:0] rptr  [NUM_PIPES];
  logic [CW-1:0] count [NUM_PIPES];

  logic [NUM_PIPES-1:0] push;
  logic [NUM_PIPES-1:0] pop;
  logic [NUM_PIPES-1:0] eligible;
  logic [IW-1:0]        rr_ptr;
  logic [IW:0]          rr_sum;
  logic                 grant_vld;
  logic [IW-1:0]        grant_idx;

  logic [REG_WIDTH-1:0] head_rd;
  logic [31:0]          head_data;
  logic                 head_wr;

  // Ready depends only on count and flush, never on this cycle's grant, so a
  // full FIFO refuses a push even while it is being popped.
  always_comb begin
    pipe_ready = '0;
    push       = '0;
    eligible   = '0;
    occupancy  = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pipe_ready[i]            = (count[i] != CW'(FIFO_DEPTH)) && !flush;
      push[i]                  = pipe_valid[i] && pipe_ready[i];
      eligible[i]              = (count[i] != '0);
      occupancy[i*CW +: CW]    = count[i];
    end
  end

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_sum    = '0;
    if (ARB_MODE == 1) begin
      // Walk from rr_ptr, wrapping modulo NUM_PIPES; first eligible wins.
      for (int k = 0; k < NUM_PIPES; k++) begin
        rr_sum = {1'b0, rr_ptr} + (IW+1)'(k);
        if (rr_sum >= (IW+1)'(NUM_PIPES))
          rr_sum = rr_sum - (IW+1)'(NUM_PIPES);
        if (!grant_vld && eligible[rr_sum[IW-1:0]]) begin
          grant_vld = 1'b1;
          grant_idx = rr_sum[IW-1:0];
        end
      end
    end else begin
      // Scan downwards so the lowest eligible index is the last one kept.
      for (int i = NUM_PIPES - 1; i >= 0; i--) begin
        if (eligible[i]) begin
          grant_vld = 1'b1;
          grant_idx = IW'(i);
        end
      end
    end
    if (flush)
      grant_vld = 1'b0;
  end

  always_comb begin
    pop = '0;
    if (grant_vld)
      pop[grant_idx] = 1'b1;
  end

  assign head_rd   = mem_rd[grant_idx][rptr[grant_idx]];
  assign head_data = mem_data[grant_idx][rptr[grant_idx]];
  assign head_wr   = mem_wr[grant_idx][rptr[grant_idx]];

  // Payload storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (push[i]) begin
        mem_rd[i][wptr[i]]   <= pipe_rd[i*REG_WIDTH +: REG_WIDTH];
        mem_data[i][wptr[i]] <= pipe_data[i*32 +: 32];
        mem_wr[i][wptr[i]]   <= pipe_reg_write[i];
      end
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        if (push[i])
          wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])
          rptr[i] <= rptr[i] + PW'(1);
        count[i] <= count[i] + CW'(push[i]) - CW'(pop[i]);
      end
    end
  end

  // rr_ptr deliberately survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (grant_vld) begin
      if (grant_idx == IW'(NUM_PIPES - 1))
        rr_ptr <= '0;
      else
        rr_ptr <= grant_idx + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_valid <= 1'b0;
      retire_pipe  <= '0;
      wb_wr_en     <= 1'b0;
      wb_rd        <= '0;
      wb_wr_data   <= '0;
    end else begin
      retire_valid <= grant_vld;
      // x0 writes are suppressed but the entry still retires.
      wb_wr_en     <= grant_vld && head_wr && (head_rd != '0);
      if (grant_vld) begin
        retire_pipe <= NUM_PIPES'(1) << grant_idx;
        wb_rd       <= head_rd;
        wb_wr_data  <= head_data;
      end else begin
        retire_pipe <= '0;
      end
    end
  end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Parametrised writeback arbiter. It collects results from `NUM_PIPES` execution pipes (ALU, LSU, MUL, DIV and future FPU/CSR pipes) into per-pipe FIFOs. Each cycle it grants one head entry, under fixed-priority or round-robin policy, to the single register-file write port feeding IX. It replaces the hard-wired fixed-priority WB mux, decoupling pipe stalls from writeback conflicts.

## Interface
Parameters:
- `NUM_PIPES`, 4: number of producer pipes; index doubles as fixed priority, 0 highest.
- `FIFO_DEPTH`, 2: entries per pipe FIFO; power of two, ≥2.
- `ARB_MODE`, 0: 0 selects fixed priority (lowest index wins); 1 selects round-robin.
- `REG_WIDTH`, 5: register index width.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `flush`, in, 1: discard all queued entries.
- `pipe_valid`, in, NUM_PIPES: per-pipe result valid.
- `pipe_ready`, out, NUM_PIPES: per-pipe FIFO can accept.
- `pipe_reg_write`, in, NUM_PIPES: entry writes the register file. If 0, the entry retires with no write.
- `pipe_rd`, in, NUM_PIPES×REG_WIDTH: destination register.
- `pipe_data`, in, NUM_PIPES×32: result data.
- `wb_wr_en`, out, 1: register-file write enable.
- `wb_rd`, out, REG_WIDTH: write index.
- `wb_wr_data`, out, 32: write data.
- `retire_valid`, out, 1: one entry retired this cycle.
- `retire_pipe`, out, NUM_PIPES: one-hot source of the retired entry.
- `occupancy`, out, NUM_PIPES×$clog2(FIFO_DEPTH+1): per-FIFO entry count.

## Operation
- **Enqueue.** Pipe i pushes when `pipe_valid[i] && pipe_ready[i]`. `pipe_ready[i] = (count_i != FIFO_DEPTH) && !flush`. Ready is not a function of same-cycle grant, so a full FIFO refuses a push even while popping.
- **FIFO.** Circular, with read/write pointers of $clog2(FIFO_DEPTH) bits that wrap modulo depth. `count` is held separately, so full and empty are unambiguous.
- **Eligibility.** Pipe i is eligible when `count_i > 0`.
- **Grant.** At most one grant per cycle. The grant pops that FIFO's head.
- **Fixed mode.** The lowest eligible index wins.
- **Round-robin mode.** The search starts at `rr_ptr` and wraps modulo NUM_PIPES; the first eligible index wins. After a grant to pipe g, `rr_ptr` becomes (g+1) mod NUM_PIPES. With no grant, `rr_ptr` holds.
- **Output register.** Granted entry drives the output flops:
  - `retire_valid` ← 1.
  - `retire_pipe` ← onehot(g).
  - `wb_rd` ← rd.
  - `wb_wr_data` ← data.
  - `wb_wr_en` ← reg_write && rd != 0, so writes to x0 are suppressed but still retire.
  - With no grant, `retire_valid` and `wb_wr_en` are 0; `wb_rd` and `wb_wr_data` hold.
- **Flush.**
  - Takes priority over push and grant in the same cycle: no grant, no push.
  - At the next edge, all counts and pointers are 0 and `retire_valid`/`wb_wr_en` are 0.
  - `rr_ptr` is unchanged.
- **Reset (async, `rst_n` low).**
  - Counts and pointers are 0; `rr_ptr` is 0.
  - `wb_wr_en`, `retire_valid`, `retire_pipe`, `wb_rd` and `wb_wr_data` are 0.
  - `pipe_ready` is all-ones once `flush` is low.
  - Reset mid-operation drops queued entries immediately, without waiting for a clock edge.
- **Simultaneous push and pop on one FIFO.** Count is unchanged and both pointers advance.

## Timing
- Push at edge N makes the entry eligible in cycle N+1. A grant in cycle N+1 makes the outputs visible after edge N+2. Minimum latency is 2 cycles, valid-in to `wb_wr_en`.
- Throughput is 1 retire per cycle in aggregate.
- A single pipe with FIFO_DEPTH ≥ 2 streams back-to-back at 1 per cycle.
- All outputs are registered except `pipe_ready`, which is combinational from count and `flush` only.
- Round-robin starvation bound: an eligible pipe is granted within NUM_PIPES cycles.
- Fixed mode makes no starvation guarantee.

## Test plan
- **Reset.** Assert `rst_n` low mid-stream with 2 entries queued in pipe 1. Required: after release, no retire; all `occupancy` = 0; `pipe_ready` = 4'b1111.
- **Fixed priority.** ARB_MODE=0, same-cycle pushes on all four pipes with rd=1..4 and data=0xA0..0xA3. Required: retires in order rd 1, 2, 3, 4 on consecutive cycles, first one 2 cycles after the push.
- **Round-robin.** ARB_MODE=1, pipes 0 and 2 held full and continuously refilled. Required: `retire_pipe` alternates 0001, 0100, 0001, …; `rr_ptr` sequence is 1, 3, 1, ….
- **Full FIFO.** FIFO_DEPTH=2, pipe 3 pushes 3 entries while pipes 0–2 are kept busy. Required: `pipe_ready[3]` = 0 on the third attempt; no entry is lost or duplicated; data order is preserved.
- **x0 and no-write entries.** Push rd=0 with data 0xDEADBEEF, then `pipe_reg_write`=0 with rd=5. Required: both retire with `retire_valid`=1 and `wb_wr_en`=0.
- **Flush vs push.** Assert `flush` in the same cycle as a push on pipe 0 while pipe 1 holds 1 entry. Required: next cycle all occupancy is 0, no retire for that entry, and nothing from the push cycle is ever written.
